// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline-control bundle between the hazard sources (master side) and the
// stall/flush sequencer (slave side). Carries the hazard requests, the
// pipeline-register enables/flushes, the watchdog flag and the perf counters.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  // Hazard requests
  logic             stall_req;
  logic             branch_taken;
  logic             mem_busy;
  // Pipeline-register controls
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Flush;
  logic             EX_MEM_Write;
  logic             MEM_WB_Flush;
  // Status
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output stall_req, branch_taken, mem_busy,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, MEM_WB_Flush, mem_timeout,
           stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  stall_req, branch_taken, mem_busy,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, MEM_WB_Flush, mem_timeout,
           stall_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Priority: mem_busy freeze > branch flush window > load-use stall > normal.
// Outputs are Mealy (state + current-cycle hazard inputs).
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt/memwait_cnt are tied to zero.
module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,   // 1..3
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  // Remaining flush cycles after the branch cycle itself.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        flush_q, flush_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              in_flush;
  logic              do_stall, do_flush;
  logic              pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f;

  // A flush window is live in FLUSH, or in MEM_WAIT when a flush was suspended.
  assign in_flush = (state_q == ST_FLUSH) ||
                    ((state_q == ST_MEM_WAIT) && (flush_q != 2'd0));

  // Next-state, flush-window and Mealy output decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d  = ST_RUN;
    flush_d  = flush_q;
    do_stall = 1'b0;
    do_flush = 1'b0;
    pc_w     = 1'b1;
    if_id_w  = 1'b1;
    if_id_f  = 1'b0;
    id_ex_w  = 1'b1;
    id_ex_f  = 1'b0;
    ex_mem_w = 1'b1;
    mem_wb_f = 1'b0;

    if (bus.mem_busy) begin
      // Freeze everything upstream of MEM; MEM/WB takes bubbles.
      state_d  = ST_MEM_WAIT;
      pc_w     = 1'b0;
      if_id_w  = 1'b0;
      id_ex_w  = 1'b0;
      ex_mem_w = 1'b0;
      mem_wb_f = 1'b1;
    end else if (in_flush) begin
      // Wrong-path cycle: branch_taken and stall_req are ignored here.
      do_flush = 1'b1;
      if_id_f  = 1'b1;
      id_ex_f  = 1'b1;
      flush_d  = flush_q - 2'd1;
      state_d  = (flush_d == 2'd0) ? ST_RUN : ST_FLUSH;
    end else if (bus.branch_taken) begin
      // PC loads the target; younger instructions are squashed.
      do_flush = 1'b1;
      if_id_f  = 1'b1;
      id_ex_f  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        flush_d = FLUSH_RELOAD;
        state_d = ST_FLUSH;
      end
    end else if (bus.stall_req) begin
      // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
      do_stall = 1'b1;
      pc_w     = 1'b0;
      if_id_w  = 1'b0;
      id_ex_f  = 1'b1;
    end

    // Reset forces all writes off and all bubbles on, regardless of state.
    if (reset) begin
      pc_w     = 1'b0;
      if_id_w  = 1'b0;
      if_id_f  = 1'b1;
      id_ex_w  = 1'b0;
      id_ex_f  = 1'b1;
      ex_mem_w = 1'b0;
      mem_wb_f = 1'b1;
    end
  end

  // Memory-wait counter (saturating) and sticky watchdog flag.
  always_comb begin
    wait_d        = '0;
    mem_timeout_d = mem_timeout_q;
    if (bus.mem_busy) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      if (wait_d == WAIT_MAX) mem_timeout_d = 1'b1;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    if (reset) begin
      state_q       <= ST_RUN;
      flush_q       <= 2'd0;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign bus.PC_Write     = pc_w;
  assign bus.IF_ID_Write  = if_id_w;
  assign bus.IF_ID_Flush  = if_id_f;
  assign bus.ID_EX_Write  = id_ex_w;
  assign bus.ID_EX_Flush  = id_ex_f;
  assign bus.EX_MEM_Write = ex_mem_w;
  assign bus.MEM_WB_Flush = mem_wb_f;
  assign bus.mem_timeout  = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  // Saturating event counters for stall, flush and memory-wait cycles.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (do_stall && !(&stall_cnt_q))        stall_cnt_d   = stall_cnt_q + 1'b1;
    if (do_flush && !(&flush_cnt_q))        flush_cnt_d   = flush_cnt_q + 1'b1;
    if (bus.mem_busy && !(&memwait_cnt_q))  memwait_cnt_d = memwait_cnt_q + 1'b1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.memwait_cnt = memwait_cnt_q;
`else
  assign bus.stall_cnt   = '0;
  assign bus.flush_cnt   = '0;
  assign bus.memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl. Two instances: FLUSH_CYCLES=3
// (sel 3) and FLUSH_CYCLES=2 (sel 2). Expected control vectors are queued
// when stimulus is driven and popped/compared mid-cycle.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector: {PC_W, IF_ID_W, IF_ID_F, ID_EX_W, ID_EX_F, EX_MEM_W, MEM_WB_F}
  localparam logic [6:0] V_NORM   = 7'b1101010;
  localparam logic [6:0] V_FLUSH  = 7'b1111110;
  localparam logic [6:0] V_STALL  = 7'b0001110;
  localparam logic [6:0] V_FREEZE = 7'b0000001;
  localparam logic [6:0] V_RESET  = 7'b0010101;

  typedef struct {
    string      tag;
    int         sel;
    logic [6:0] exp;
  } sb_item_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  sb_item_t sb_q[$];

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus3 ();
  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus2 ();

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );
  pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(64), .CNT_W(CNT_W)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] out_vec(input int sel);
    if (sel == 2)
      return {bus2.PC_Write, bus2.IF_ID_Write, bus2.IF_ID_Flush, bus2.ID_EX_Write,
              bus2.ID_EX_Flush, bus2.EX_MEM_Write, bus2.MEM_WB_Flush};
    return {bus3.PC_Write, bus3.IF_ID_Write, bus3.IF_ID_Flush, bus3.ID_EX_Write,
            bus3.ID_EX_Flush, bus3.EX_MEM_Write, bus3.MEM_WB_Flush};
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic drive(input int sel, input logic sr, input logic bt, input logic mb);
    bus3.stall_req    = (sel == 3) ? sr : 1'b0;
    bus3.branch_taken = (sel == 3) ? bt : 1'b0;
    bus3.mem_busy     = (sel == 3) ? mb : 1'b0;
    bus2.stall_req    = (sel == 2) ? sr : 1'b0;
    bus2.branch_taken = (sel == 2) ? bt : 1'b0;
    bus2.mem_busy     = (sel == 2) ? mb : 1'b0;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, return at next posedge+1.
  task automatic step(input int sel, input logic sr, input logic bt, input logic mb,
                      input logic [6:0] exp, input string tag);
    sb_item_t it;
    drive(sel, sr, bt, mb);
    sb_q.push_back('{tag, sel, exp});
    @(negedge clk);
    it = sb_q.pop_front();
    check(it.tag, 64'(out_vec(it.sel)), 64'(it.exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_vec3", 64'(out_vec(3)), 64'(V_RESET));
    check("reset_vec2", 64'(out_vec(2)), 64'(V_RESET));
    check("reset_tmo", 64'(bus3.mem_timeout), 64'd0);
    check("reset_cnt", 64'(bus3.flush_cnt), 64'd0);
    reset = 1'b0;

    // Normal cycle and single-cycle load-use stall
    step(3, 0, 0, 0, V_NORM,  "norm");
    step(3, 1, 0, 0, V_STALL, "stall1");
    step(3, 0, 0, 0, V_NORM,  "after_stall");
    check("stall_cnt3", 64'(bus3.stall_cnt), 64'(exp_cnt(1)));

    // FLUSH_CYCLES=2 branch; stall_req in the 2nd flush cycle is ignored
    step(2, 0, 1, 0, V_FLUSH, "br2_c1");
    step(2, 1, 0, 0, V_FLUSH, "br2_c2_stall_ignored");
    step(2, 0, 0, 0, V_NORM,  "br2_done");
    check("flush_cnt2", 64'(bus2.flush_cnt), 64'(exp_cnt(2)));
    check("stall_cnt2", 64'(bus2.stall_cnt), 64'(exp_cnt(0)));

    // FLUSH_CYCLES=3 branch, 5-cycle memory wait after the first flush cycle
    step(3, 0, 1, 0, V_FLUSH, "br3_c1");
    for (int i = 0; i < 5; i++) step(3, 0, 0, 1, V_FREEZE, "br3_freeze");
    step(3, 0, 0, 0, V_FLUSH, "br3_resume_c2");
    step(3, 1, 1, 0, V_FLUSH, "br3_resume_c3");
    step(3, 0, 0, 0, V_NORM,  "br3_done");
    check("memwait_cnt3", 64'(bus3.memwait_cnt), 64'(exp_cnt(5)));
    check("flush_cnt3",   64'(bus3.flush_cnt),   64'(exp_cnt(3)));
    check("stall_cnt3_b", 64'(bus3.stall_cnt),   64'(exp_cnt(1)));

    // Branch and stall together: branch wins, stall dropped
    step(2, 1, 1, 0, V_FLUSH, "br_stall_c1");
    step(2, 0, 0, 0, V_FLUSH, "br_stall_c2");
    step(2, 0, 0, 0, V_NORM,  "br_stall_done");
    check("stall_cnt2_b", 64'(bus2.stall_cnt), 64'(exp_cnt(0)));
    check("flush_cnt2_b", 64'(bus2.flush_cnt), 64'(exp_cnt(4)));

    // Watchdog: trips on the 64th consecutive busy edge, sticky afterwards
    for (int i = 0; i < 63; i++) step(3, 0, 0, 1, V_FREEZE, "wd_freeze");
    check("wd_before", 64'(bus3.mem_timeout), 64'd0);
    step(3, 0, 0, 1, V_FREEZE, "wd_freeze64");
    check("wd_trip", 64'(bus3.mem_timeout), 64'd1);
    step(3, 0, 0, 0, V_NORM, "wd_resume");
    check("wd_sticky", 64'(bus3.mem_timeout), 64'd1);
    check("memwait_cnt3_b", 64'(bus3.memwait_cnt), 64'(exp_cnt(69)));

    // Reset in the second cycle of a FLUSH_CYCLES=3 flush
    step(3, 0, 1, 0, V_FLUSH, "rst_br_c1");
    drive(0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midflush_rst_vec", 64'(out_vec(3)), 64'(V_RESET));
    check("midflush_rst_tmo", 64'(bus3.mem_timeout), 64'd0);
    check("midflush_rst_cnt", 64'(bus3.memwait_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(3, 0, 0, 0, V_NORM, "post_rst_norm3");
    step(2, 0, 0, 0, V_NORM, "post_rst_norm2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
